// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit. Each cycle in SHIFT applies one barrel stage
// (a shift by 2^k), so an operation takes a fixed SHAMT_W+1 cycles.
module shift_unit #(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shiftamt,
  input  logic [2:0]         mode,
  output logic [WIDTH-1:0]   out,
  output logic               data_resultRDY,
  output logic               data_exception,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [2:0] M_SLL = 3'b000;
  localparam logic [2:0] M_SRL = 3'b001;
  localparam logic [2:0] M_SRA = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;
  localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);

  state_t             state, state_n;
  logic [SHAMT_W-1:0] k;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] amt;
  logic [2:0]         mode_q;
  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   stage_val;

  // One barrel stage: move the word by 2^k places. Invalid modes pass through.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] w,
                                                   input logic [SHAMT_W-1:0] kk,
                                                   input logic [2:0] m);
    int sh;
    logic signed [WIDTH-1:0] s;
    sh = 1 << kk;
    s  = w;
    case (m)
      M_SLL:   shift_stage = w << sh;
      M_SRL:   shift_stage = w >> sh;
      M_SRA:   begin
        // MSB of the working word is still the original sign bit.
        s = s >>> sh;
        shift_stage = s;
      end
      M_ROL:   shift_stage = (w << sh) | (w >> (WIDTH - sh));
      M_ROR:   shift_stage = (w >> sh) | (w << (WIDTH - sh));
      default: shift_stage = w;
    endcase
  endfunction

  always_comb begin
    stage_val = amt[k] ? shift_stage(work, k, mode_q) : work;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    last    = (k == K_LAST);
    case (state)
      IDLE, DONE: begin
        if (ctrl_start) begin
          state_n = SHIFT;
          accept  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT:   if (last) state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      k   <= '0;
      out <= '0;
    end else if (accept) begin
      work   <= data_in;
      amt    <= shiftamt;
      mode_q <= mode;
      k      <= '0;
    end else if (state == SHIFT) begin
      work <= stage_val;
      if (last) begin
        out <= stage_val;
        k   <= '0;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  assign busy           = (state == SHIFT);
  assign data_resultRDY = (state == DONE);
  assign data_exception = (state == DONE) && (mode_q > M_ROR);

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: a 32-bit instance and an 8-bit instance on one clock.
module tb_shift_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start32, start8;
  logic [31:0] din32, out32;
  logic [4:0]  amt32;
  logic [2:0]  mode32, mode8;
  logic [7:0]  din8, out8;
  logic [2:0]  amt8;
  logic        rdy32, exc32, busy32, rdy8, exc8, busy8;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  shift_unit #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .ctrl_start(start32), .data_in(din32),
    .shiftamt(amt32), .mode(mode32), .out(out32), .data_resultRDY(rdy32),
    .data_exception(exc32), .busy(busy32)
  );

  shift_unit #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .ctrl_start(start8), .data_in(din8),
    .shiftamt(amt8), .mode(mode8), .out(out8), .data_resultRDY(rdy8),
    .data_exception(exc8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present operands and hold ctrl_start through one rising edge (edge 1),
  // then scramble the inputs to show they are not needed after acceptance.
  task automatic issue32(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m);
    din32 = d; amt32 = a; mode32 = m; start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0; din32 = ~d; amt32 = ~a; mode32 = 3'b001;
  endtask

  // Called #1 after edge 1. Walks edges 2..6, optionally pulsing a start
  // mid-operation, then checks the result in the DONE cycle.
  task automatic finish32(input string tag, input logic [31:0] exp, input logic ex,
                          input logic glitch);
    int busy_cnt = 0;
    int rdy_cnt  = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy32) busy_cnt++;
      if (rdy32)  rdy_cnt++;
      if (glitch && i == 1) begin
        start32 = 1'b1; din32 = 32'h5555_5555; amt32 = 5'd3; mode32 = 3'b000;
      end else begin
        start32 = 1'b0;
      end
      @(posedge clock); #1;
    end
    start32 = 1'b0;
    check({tag, "_busy_cycles"}, busy_cnt, 5);
    check({tag, "_early_rdy"}, rdy_cnt, 0);
    check({tag, "_rdy"}, rdy32, 1'b1);
    check({tag, "_out"}, out32, exp);
    check({tag, "_exc"}, exc32, ex);
    check({tag, "_busy_done"}, busy32, 1'b0);
  endtask

  task automatic op32(input string tag, input logic [31:0] d, input logic [4:0] a,
                      input logic [2:0] m, input logic [31:0] exp, input logic ex);
    @(negedge clock);
    issue32(d, a, m);
    finish32(tag, exp, ex, 1'b0);
  endtask

  task automatic idle32(input string tag, input logic [31:0] exp);
    @(posedge clock); #1;
    check({tag, "_rdy_low"}, rdy32, 1'b0);
    check({tag, "_exc_low"}, exc32, 1'b0);
    check({tag, "_idle_busy"}, busy32, 1'b0);
    check({tag, "_out_hold"}, out32, exp);
  endtask

  task automatic op8(input string tag, input logic [7:0] d, input logic [2:0] a,
                     input logic [2:0] m, input logic [7:0] exp);
    int busy_cnt = 0;
    int rdy_cnt  = 0;
    @(negedge clock);
    din8 = d; amt8 = a; mode8 = m; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0; din8 = 8'h00; amt8 = 3'd0; mode8 = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (busy8) busy_cnt++;
      if (rdy8)  rdy_cnt++;
      @(posedge clock); #1;
    end
    check({tag, "_busy_cycles"}, busy_cnt, 3);
    check({tag, "_early_rdy"}, rdy_cnt, 0);
    check({tag, "_rdy"}, rdy8, 1'b1);
    check({tag, "_out"}, out8, exp);
    check({tag, "_exc"}, exc8, 1'b0);
    @(posedge clock); #1;
    check({tag, "_rdy_low"}, rdy8, 1'b0);
  endtask

  initial begin
    int rdy_cnt;
    reset = 1'b1; start32 = 1'b0; start8 = 1'b0;
    din32 = 32'h0; amt32 = 5'd0; mode32 = 3'b000;
    din8 = 8'h0; amt8 = 3'd0; mode8 = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out32", out32, 32'h0);
    check("rst_rdy32", rdy32, 1'b0);
    check("rst_exc32", exc32, 1'b0);
    check("rst_busy32", busy32, 1'b0);
    check("rst_out8", out8, 8'h0);
    check("rst_busy8", busy8, 1'b0);
    reset = 1'b0;

    op32("sra300", 32'd300, 5'd17, 3'b010, 32'h0000_0000, 1'b0);
    idle32("sra300", 32'h0000_0000);
    op32("sra_neg4", 32'h8000_0000, 5'd4, 3'b010, 32'hF800_0000, 1'b0);
    op32("sra_neg31", 32'h8000_0000, 5'd31, 3'b010, 32'hFFFF_FFFF, 1'b0);
    op32("sll5", 32'hA5A5_A5A5, 5'd5, 3'b000, 32'hB4B4_B4A0, 1'b0);
    op32("ror8", 32'h1234_5678, 5'd8, 3'b100, 32'h7812_3456, 1'b0);
    op32("rol1", 32'h8000_0001, 5'd1, 3'b011, 32'h0000_0003, 1'b0);
    op32("rol31", 32'h0000_0001, 5'd31, 3'b011, 32'h8000_0000, 1'b0);
    op32("srl31", 32'h0000_FFFF, 5'd31, 3'b001, 32'h0000_0000, 1'b0);
    op32("srl4", 32'hF000_000F, 5'd4, 3'b001, 32'h0F00_0000, 1'b0);

    // Back-to-back: second start issued during the first DONE cycle.
    op32("b2b_a", 32'h0000_00F0, 5'd4, 3'b000, 32'h0000_0F00, 1'b0);
    issue32(32'h0000_0F00, 5'd8, 3'b001);
    finish32("b2b_b", 32'h0000_000F, 1'b0, 1'b0);
    idle32("b2b_b", 32'h0000_000F);

    // Start pulsed mid-operation must be ignored.
    @(negedge clock);
    issue32(32'h1234_5678, 5'd4, 3'b100);
    finish32("glitch", 32'h8123_4567, 1'b0, 1'b1);
    idle32("glitch", 32'h8123_4567);

    // Reset asserted so that it takes effect on edge 3.
    @(negedge clock);
    issue32(32'hFFFF_0000, 5'd1, 3'b000);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_out", out32, 32'h0);
    check("midrst_busy", busy32, 1'b0);
    rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (rdy32 || busy32) rdy_cnt++;
      @(posedge clock); #1;
    end
    check("midrst_no_activity", rdy_cnt, 0);
    op32("after_rst", 32'h0000_0003, 5'd2, 3'b000, 32'h0000_000C, 1'b0);

    // Reset wins over a simultaneous start.
    @(negedge clock);
    reset = 1'b1; start32 = 1'b1; din32 = 32'h1;
    @(posedge clock); #1;
    reset = 1'b0; start32 = 1'b0;
    check("rst_prio_busy", busy32, 1'b0);
    check("rst_prio_out", out32, 32'h0);

    op32("invalid101", 32'hDEAD_BEEF, 5'd5, 3'b101, 32'hDEAD_BEEF, 1'b1);
    idle32("invalid101", 32'hDEAD_BEEF);
    op32("invalid111", 32'h0F0F_0F0F, 5'd31, 3'b111, 32'h0F0F_0F0F, 1'b1);
    op32("zero_amt", 32'h1357_9BDF, 5'd0, 3'b000, 32'h1357_9BDF, 1'b0);

    op8("w8_sra7", 8'h81, 3'd7, 3'b010, 8'hFF);
    op8("w8_rol3", 8'h81, 3'd3, 3'b011, 8'h0C);
    op8("w8_ror1", 8'h81, 3'd1, 3'b100, 8'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
